// File: rtl/ask4_pkg.sv
// Shared definitions for the 4-ASK link: PRBS constants, symbol type and the Gray amplitude mapper.
// The mapper is also used by the receive-side slicer reference.
package ask4_pkg;

  localparam int unsigned LFSR_W   = 22;
  localparam int unsigned TAP_HI   = 21;
  localparam int unsigned TAP_LO   = 20;
  localparam int unsigned SAMPLE_W = 18;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 22'h3FFFFF;

  localparam logic signed [SAMPLE_W-1:0] A_UNIT = 18'sd32768;

  typedef logic [1:0] sym_t;
  typedef logic [LFSR_W-1:0] lfsr_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sym_t SYM_NEG3 = 2'b00;
  localparam sym_t SYM_NEG1 = 2'b01;
  localparam sym_t SYM_POS1 = 2'b11;
  localparam sym_t SYM_POS3 = 2'b10;

  // Fibonacci step for x^22 + x^21 + 1; the all-zero state is never entered from the seed.
  function automatic lfsr_t lfsr_step(input lfsr_t state);
    lfsr_step = {state[LFSR_W-2:0], state[TAP_HI] ^ state[TAP_LO]};
  endfunction

  // 3a at scale 0 is 98304, which still fits 1s17, so no saturation is required.
  function automatic sample_t map_4ask(input sym_t bits, input logic [2:0] scale);
    sample_t a;
    sample_t a3;
    a  = A_UNIT >>> scale;
    a3 = a + (a <<< 1);
    case (bits)
      SYM_NEG3: map_4ask = -a3;
      SYM_NEG1: map_4ask = -a;
      SYM_POS1: map_4ask = a;
      default:  map_4ask = a3;
    endcase
  endfunction

endpackage

// File: rtl/ask4_strobe_gen.sv
// Sample/symbol strobe generator and measurement-block counter for the 4-ASK transmit source.
// sam/sym strobes are decoded from counter state; meas_strobe is registered.
module ask4_strobe_gen #(
  parameter int unsigned SAM_DIV   = 2,
  parameter int unsigned SPS       = 4,
  parameter int unsigned MEAS_LOG2 = 20
) (
  input  logic sys_clk,
  input  logic reset_n,
  output logic sam_clk_en,
  output logic sym_clk_en,
  output logic meas_strobe
);

  localparam int unsigned DIV_W = $clog2(SAM_DIV);
  localparam int unsigned PH_W  = $clog2(SPS);
  localparam int unsigned CNT_W = MEAS_LOG2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAM_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             meas_strobe_q, meas_strobe_d;
  logic             sym_wrap;

  always_comb begin
    sam_clk_en  = (div_cnt_q == DIV_LAST);
    sym_clk_en  = sam_clk_en && (phase_q == PH_LAST);
    sym_wrap    = sym_clk_en && (&sym_cnt_q);
    meas_strobe = meas_strobe_q;
  end

  always_comb begin
    div_cnt_d     = sam_clk_en ? '0 : div_cnt_q + DIV_W'(1);
    phase_d       = phase_q;
    sym_cnt_d     = sym_cnt_q;
    meas_strobe_d = sym_wrap;
    if (sam_clk_en) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end
    if (sym_clk_en) begin
      sym_cnt_d = sym_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      phase_q       <= '0;
      sym_cnt_q     <= '0;
      meas_strobe_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      phase_q       <= phase_d;
      sym_cnt_q     <= sym_cnt_d;
      meas_strobe_q <= meas_strobe_d;
    end
  end

endmodule

// File: rtl/ask4_tx_source.sv
// 4-ASK transmit stimulus source: PRBS symbols, Gray amplitude mapping, upsampled filter input.
// Define ASK_TX_ZOH_EN to hold the symbol amplitude on every sample instead of zero insertion.
module ask4_tx_source
  import ask4_pkg::*;
#(
  parameter int unsigned SAM_DIV   = 2,
  parameter int unsigned SPS       = 4,
  parameter int unsigned MEAS_LOG2 = 20
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic [2:0]         scale,
  output logic               sam_clk_en,
  output logic               sym_clk_en,
  output logic [1:0]         sym_bits,
  output logic signed [17:0] x_in,
  output logic               meas_strobe
);

  lfsr_t   lfsr_q, lfsr_d, next_lfsr;
  sym_t    sym_bits_q, sym_bits_d;
  sample_t x_in_q, x_in_d;

  ask4_strobe_gen #(
    .SAM_DIV   (SAM_DIV),
    .SPS       (SPS),
    .MEAS_LOG2 (MEAS_LOG2)
  ) u_strobe_gen (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en),
    .meas_strobe (meas_strobe)
  );

  // scale is only looked at on the symbol edge, so an emitted symbol is never rescaled.
  always_comb begin
    next_lfsr  = lfsr_step(lfsr_q);
    lfsr_d     = lfsr_q;
    sym_bits_d = sym_bits_q;
    x_in_d     = x_in_q;
    if (sym_clk_en) begin
      lfsr_d     = next_lfsr;
      sym_bits_d = next_lfsr[1:0];
      x_in_d     = map_4ask(next_lfsr[1:0], scale);
    end else if (sam_clk_en) begin
`ifdef ASK_TX_ZOH_EN
      x_in_d = x_in_q;
`else
      x_in_d = '0;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q     <= LFSR_SEED;
      sym_bits_q <= '0;
      x_in_q     <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      sym_bits_q <= sym_bits_d;
      x_in_q     <= x_in_d;
    end
  end

  always_comb begin
    sym_bits = sym_bits_q;
    x_in     = x_in_q;
  end

endmodule

// File: tb/tb_ask4_tx_source.sv
// Directed bench for ask4_tx_source with SAM_DIV=2, SPS=4, MEAS_LOG2=4.
// Outputs are sampled on the falling edge; expected values are hand-derived constants.
module tb_ask4_tx_source;

  logic               sys_clk;
  logic               reset_n;
  logic [2:0]         scale;
  logic               sam_clk_en;
  logic               sym_clk_en;
  logic [1:0]         sym_bits;
  logic signed [17:0] x_in;
  logic               meas_strobe;

  int vectors;
  int miscompares;

  ask4_tx_source #(
    .SAM_DIV   (2),
    .SPS       (4),
    .MEAS_LOG2 (4)
  ) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .scale       (scale),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en),
    .sym_bits    (sym_bits),
    .x_in        (x_in),
    .meas_strobe (meas_strobe)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Symbol bits from seed 3FFFFF: 10 first, then 00 except where listed.
  function automatic int exp_bits(input int n);
    case (n)
      1:       exp_bits = 2;
      22:      exp_bits = 1;
      23:      exp_bits = 2;
      43:      exp_bits = 1;
      44:      exp_bits = 3;
      45:      exp_bits = 2;
      default: exp_bits = 0;
    endcase
  endfunction

  function automatic int level(input int bits, input int sc);
    if (sc == 0) begin
      case (bits)
        0:       level = -98304;
        1:       level = -32768;
        3:       level = 32768;
        default: level = 98304;
      endcase
    end else begin
      case (bits)
        0:       level = -24576;
        1:       level = -8192;
        3:       level = 8192;
        default: level = 24576;
      endcase
    end
  endfunction

  // Leaves the bench on the falling edge just after the next symbol edge.
  task automatic next_symbol();
    int n;
    n = 0;
    while (sym_clk_en !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check("sym_timeout", (n < 20), 1);
    @(negedge sys_clk);
  endtask

  initial begin
    int amp;
    int exp_x;
    int sc;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    scale       = 3'd0;

    repeat (3) @(negedge sys_clk);
    check("rst_sam", sam_clk_en, 0);
    check("rst_sym", sym_clk_en, 0);
    check("rst_x", x_in, 0);
    check("rst_bits", sym_bits, 0);
    check("rst_meas", meas_strobe, 0);

    // Value shown before edge k, where edge 0 is the first rising edge after release.
    reset_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      case (k / 8)
        1:       amp = 98304;
        default: amp = -98304;
      endcase
`ifdef ASK_TX_ZOH_EN
      exp_x = (k >= 8) ? amp : 0;
`else
      exp_x = (k >= 8 && (k % 8) < 2) ? amp : 0;
`endif
      check("t_sam", sam_clk_en, ((k % 2) == 1));
      check("t_sym", sym_clk_en, ((k % 8) == 7));
      check("t_x", x_in, exp_x);
      check("t_bits", sym_bits, (k >= 8) ? exp_bits(k / 8) : 0);
      check("t_meas", meas_strobe, 0);
      @(negedge sys_clk);
    end

    for (int n = 5; n <= 45; n++) begin
      next_symbol();
      sc = (n >= 22 && n <= 44) ? 2 : 0;
      check("s_bits", sym_bits, exp_bits(n));
      check("s_x", x_in, level(exp_bits(n), sc));
      check("s_meas", meas_strobe, ((n % 16) == 0));
      if ((n % 16) == 0) begin
        @(negedge sys_clk);
        check("meas_one_cycle", meas_strobe, 0);
      end
      // Change scale mid-symbol; the symbol already on x_in must keep its amplitude.
      if (n == 21 || n == 44) begin
        scale = (n == 21) ? 3'd2 : 3'd0;
        @(negedge sys_clk);
        check("scale_hold", x_in, level(exp_bits(n), sc));
      end
    end

    @(negedge sys_clk);
    check("pre_rst_sam", sam_clk_en, 1);
    check("pre_rst_x", x_in, 98304);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sam", sam_clk_en, 0);
    check("mid_rst_sym", sym_clk_en, 0);
    check("mid_rst_x", x_in, 0);
    check("mid_rst_bits", sym_bits, 0);
    check("mid_rst_meas", meas_strobe, 0);
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check("re_sym", sym_clk_en, (k == 7));
      if (k == 8) begin
        check("re_bits", sym_bits, 2);
        check("re_x", x_in, 98304);
      end
      @(negedge sys_clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
